// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-side hazard inputs and stall/flush/status outputs of the hazard unit.
interface hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH = 32
);
  logic rs1_rd_en_id;
  logic rs2_rd_en_id;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex;
  logic mem_read_ex;
  logic branch_taken_ex;
  logic mem_req_mem;
  logic mem_ready_mem;
  logic err_clr;
  logic stall_pc;
  logic stall_if_id;
  logic stall_id_ex;
  logic stall_ex_mem;
  logic flush_if_id;
  logic flush_id_ex;
  logic flush_mem_wb;
  logic mem_timeout_err;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  modport master (
    output rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id, rd_addr_ex, mem_read_ex,
           branch_taken_ex, mem_req_mem, mem_ready_mem, err_clr,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
           flush_mem_wb, mem_timeout_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  rs1_rd_en_id, rs2_rd_en_id, rs1_addr_id, rs2_addr_id, rd_addr_ex, mem_read_ex,
           branch_taken_ex, mem_req_mem, mem_ready_mem, err_clr,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex,
           flush_mem_wb, mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / branch / memory-wait stall and flush control with wait watchdog and perf counters.
module hazard_unit #(
  parameter int CNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  hazard_unit_if.slave hu
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic err_q, err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic load_use, mem_wait, mw, br, lu;
  always_comb begin
    load_use = hu.mem_read_ex && hu.rd_addr_ex != '0 &&
               ((hu.rs1_rd_en_id && hu.rs1_addr_id == hu.rd_addr_ex) ||
                (hu.rs2_rd_en_id && hu.rs2_addr_id == hu.rd_addr_ex));
    mem_wait = hu.mem_req_mem && !hu.mem_ready_mem;
    mw = rst_n && mem_wait;
    br = rst_n && !mem_wait && hu.branch_taken_ex;
    lu = rst_n && !mem_wait && !hu.branch_taken_ex && load_use;
    hu.stall_pc = mw || lu;
    hu.stall_if_id = mw || lu;
    hu.stall_id_ex = mw;
    hu.stall_ex_mem = mw;
    hu.flush_if_id = br;
    hu.flush_id_ex = br || lu;
    hu.flush_mem_wb = mw;
    state_d = mem_wait ? MEM_WAIT : RUN;
    wait_d = state_q == RUN ? '0 : (wait_q == WW'(MEM_TIMEOUT) ? wait_q : wait_q + WW'(1));
    err_d = (state_q == MEM_WAIT && mem_wait && wait_q == WW'(MEM_TIMEOUT)) ? 1'b1 :
            (hu.err_clr ? 1'b0 : err_q);
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(mw || lu);
    flush_cnt_d = flush_cnt_q + CNT_WIDTH'(br || lu);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q <= '0;
      err_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      err_q <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hu.mem_timeout_err = err_q;
  assign hu.stall_cnt = stall_cnt_q;
  assign hu.flush_cnt = flush_cnt_q;
endmodule
